// File: rtl/regfile_pkg.sv
// Shared types and constants for the multi-port register file.
package regfile_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    INIT = 1'b1
  } state_e;

  localparam int MAX_NUM_RD    = 4;
  localparam int DEFAULT_WIDTH = 64;

endpackage

// File: rtl/regfile_init_seq.sv
// Init sequencer: walks mem[i] <= i over every entry, one entry per cycle.
module regfile_init_seq
  import regfile_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int AW    = $clog2(DEPTH),
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             init_req,
  output logic             init_busy,
  output logic             init_we,
  output logic [AW-1:0]    init_addr,
  output logic [WIDTH-1:0] init_data
);

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  state_e        state_q;
  logic [AW-1:0] cnt_q;
  logic          busy_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (init_req) begin
            state_q <= INIT;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        INIT: begin
          if (cnt_q == LAST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q + AW'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign init_busy = busy_q;
  assign init_we   = (state_q == INIT);
  assign init_addr = cnt_q;
  assign init_data = WIDTH'(cnt_q);

endmodule

// File: rtl/regfile_mp.sv
// Parametrised register file: NUM_RD registered read ports, write-first bypass, init sequence.
// REGFILE_ZERO_REG_EN hard-wires entry DEPTH-1 to zero.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int DEPTH  = 32,
  parameter int NUM_RD = 2,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    init_req,
  output logic                    init_busy,
  input  logic [NUM_RD*AW-1:0]    rd_addr,
  output logic [NUM_RD*WIDTH-1:0] rd_data,
  input  logic                    wr_en,
  input  logic [AW-1:0]           wr_addr,
  input  logic [WIDTH-1:0]        wr_data
);

  if (NUM_RD < 1 || NUM_RD > MAX_NUM_RD) begin : g_bad_num_rd
    $error("regfile_mp: NUM_RD out of range");
  end

  localparam logic [AW:0] LIMIT = (AW+1)'(DEPTH);
`ifdef REGFILE_ZERO_REG_EN
  localparam logic [AW-1:0] ZREG = AW'(DEPTH - 1);
`endif

  // An address is live when it names a real, writable-and-readable entry.
  function automatic logic addr_ok(input logic [AW-1:0] a);
    logic ok;
    ok = ({1'b0, a} < LIMIT);
`ifdef REGFILE_ZERO_REG_EN
    if (a == ZREG) ok = 1'b0;
`endif
    return ok;
  endfunction

  logic [WIDTH-1:0]        mem_q [DEPTH];
  logic [NUM_RD*WIDTH-1:0] rd_data_q;
  logic [WIDTH-1:0]        rd_d  [NUM_RD];

  logic             init_we;
  logic [AW-1:0]    init_addr;
  logic [WIDTH-1:0] init_data;

  logic             we;
  logic [AW-1:0]    waddr;
  logic [WIDTH-1:0] wdata;

  regfile_init_seq #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .WIDTH (WIDTH)
  ) u_init_seq (
    .clk       (clk),
    .reset     (reset),
    .init_req  (init_req),
    .init_busy (init_busy),
    .init_we   (init_we),
    .init_addr (init_addr),
    .init_data (init_data)
  );

  // init_we is high exactly while INIT, so it also masks the external strobe.
  always_comb begin
    we    = 1'b0;
    waddr = wr_addr;
    wdata = wr_data;
    if (init_we) begin
      we    = addr_ok(init_addr);
      waddr = init_addr;
      wdata = init_data;
    end else begin
      we = wr_en && addr_ok(wr_addr);
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [AW-1:0] a;
    assign a = rd_addr[k*AW +: AW];
    assign rd_d[k] = !addr_ok(a)         ? '0    :
                     (we && a == waddr)  ? wdata :
                                           mem_q[a];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_data_q <= '0;
    end else begin
      for (int unsigned k = 0; k < NUM_RD; k++) rd_data_q[k*WIDTH +: WIDTH] <= rd_d[k];
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: default instance plus a non-power-of-2 depth instance.
module tb_regfile_mp;

  localparam int W   = 64;
  localparam int D   = 32;
  localparam int NR  = 2;
  localparam int AW  = 5;
  localparam int W2  = 16;
  localparam int D2  = 24;
  localparam int NR2 = 3;
  localparam int AW2 = 5;
`ifdef REGFILE_ZERO_REG_EN
  localparam bit ZR = 1'b1;
`else
  localparam bit ZR = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            init_req = 1'b0;
  logic            init_busy;
  logic [NR*AW-1:0] rd_addr = '0;
  logic [NR*W-1:0]  rd_data;
  logic            wr_en = 1'b0;
  logic [AW-1:0]   wr_addr = '0;
  logic [W-1:0]    wr_data = '0;

  logic              init_req2 = 1'b0;
  logic              init_busy2;
  logic [NR2*AW2-1:0] rd_addr2 = '0;
  logic [NR2*W2-1:0]  rd_data2;
  logic              wr_en2 = 1'b0;
  logic [AW2-1:0]    wr_addr2 = '0;
  logic [W2-1:0]     wr_data2 = '0;

  int checks = 0;
  int failures = 0;

  logic [W-1:0]  m_mem  [D];
  logic [W2-1:0] m2_mem [D2];
  logic [W-1:0]  m_exp  [NR];
  logic [W2-1:0] m2_exp [NR2];
  bit            m_init;
  int            m_cnt;

  always #5 clk = ~clk;

  regfile_mp #(.WIDTH(W), .DEPTH(D), .NUM_RD(NR)) u_dut (
    .clk(clk), .reset(reset), .init_req(init_req), .init_busy(init_busy),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  regfile_mp #(.WIDTH(W2), .DEPTH(D2), .NUM_RD(NR2)) u_dut2 (
    .clk(clk), .reset(reset), .init_req(init_req2), .init_busy(init_busy2),
    .rd_addr(rd_addr2), .rd_data(rd_data2),
    .wr_en(wr_en2), .wr_addr(wr_addr2), .wr_data(wr_data2)
  );

  function automatic bit is_zero_reg(int a, int depth);
    return ZR && (a == depth - 1);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < D; i++) m_mem[i] = '0;
    for (int i = 0; i < D2; i++) m2_mem[i] = '0;
    for (int k = 0; k < NR; k++) m_exp[k] = '0;
    for (int k = 0; k < NR2; k++) m2_exp[k] = '0;
    m_init = 1'b0;
    m_cnt  = 0;
  endtask

  // Reference model: predicts the result of the next edge from the spec rules, then clocks it.
  task automatic cycle();
    int wa, wa2, a;
    bit wv, wv2;
    logic [W-1:0] wd;
    wv = 1'b0; wa = 0; wd = '0;
    if (m_init) begin
      wv = 1'b1; wa = m_cnt; wd = W'(m_cnt);
    end else if (wr_en) begin
      wv = 1'b1; wa = int'(wr_addr); wd = wr_data;
    end
    if (wa >= D || is_zero_reg(wa, D)) wv = 1'b0;
    for (int k = 0; k < NR; k++) begin
      a = int'(rd_addr[k*AW +: AW]);
      if (a >= D || is_zero_reg(a, D)) m_exp[k] = '0;
      else if (wv && a == wa)          m_exp[k] = wd;
      else                             m_exp[k] = m_mem[a];
    end
    wa2 = int'(wr_addr2);
    wv2 = wr_en2 && wa2 < D2 && !is_zero_reg(wa2, D2);
    for (int k = 0; k < NR2; k++) begin
      a = int'(rd_addr2[k*AW2 +: AW2]);
      if (a >= D2 || is_zero_reg(a, D2)) m2_exp[k] = '0;
      else if (wv2 && a == wa2)          m2_exp[k] = wr_data2;
      else                               m2_exp[k] = m2_mem[a];
    end
    if (wv) m_mem[wa] = wd;
    if (wv2) m2_mem[wa2] = wr_data2;
    if (m_init) begin
      if (m_cnt == D - 1) m_init = 1'b0;
      else m_cnt++;
    end else if (init_req) begin
      m_init = 1'b1;
      m_cnt  = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic randomize_inputs(bit allow_init);
    wr_en    = 1'($urandom_range(0, 1));
    wr_addr  = AW'($urandom_range(0, D - 1));
    wr_data  = {$urandom, $urandom};
    init_req = allow_init && ($urandom_range(0, 49) == 0);
    for (int k = 0; k < NR; k++) rd_addr[k*AW +: AW] = AW'($urandom_range(0, D - 1));
    wr_en2   = 1'($urandom_range(0, 1));
    wr_addr2 = AW2'($urandom_range(0, 31));
    wr_data2 = W2'($urandom);
    for (int k = 0; k < NR2; k++) rd_addr2[k*AW2 +: AW2] = AW2'($urandom_range(0, 31));
  endtask

  task automatic idle_inputs();
    wr_en = 1'b0; init_req = 1'b0; wr_en2 = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    #2 reset = 1'b0;
    #1;
    model_reset();
    checks++;
    if (rd_data !== '0 || init_busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_async rd_data=%h busy=%b expected 0/0", rd_data, init_busy);
    end
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 64'h1111;
    rd_addr = {5'd5, 5'd5};
    @(posedge clk); #1;
    checks++;
    if (rd_data !== '0 || rd_data2 !== '0) begin
      failures++;
      $display("FAIL reset_hold rd_data=%h rd_data2=%h expected 0", rd_data, rd_data2);
    end
    wr_en = 1'b0;
    @(negedge clk) reset = 1'b1;
    rd_addr = {5'd5, 5'd0};
    cycle();
    rd_addr = {5'd0, 5'd31};
    cycle();
    for (int k = 0; k < NR; k++) begin
      checks++;
      if (rd_data[k*W +: W] !== '0) begin
        failures++;
        $display("FAIL reset_read port%0d got=%h expected=0", k, rd_data[k*W +: W]);
      end
    end
  endtask

  task automatic test_write_latency();
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 64'hDEADBEEF_CAFEF00D;
    rd_addr = {5'd0, 5'd0};
    cycle();
    checks++;
    if (rd_data[W +: W] !== m_exp[1] || rd_data[W +: W] === 64'hDEADBEEF_CAFEF00D) begin
      failures++;
      $display("FAIL latency_early port1 got=%h expected=%h", rd_data[W +: W], m_exp[1]);
    end
    wr_en = 1'b0;
    rd_addr = {5'd7, 5'd0};
    checks++;
    if (rd_data[W +: W] === 64'hDEADBEEF_CAFEF00D) begin
      failures++;
      $display("FAIL latency_comb port1 got=%h expected old value before edge", rd_data[W +: W]);
    end
    cycle();
    checks++;
    if (rd_data[W +: W] !== 64'hDEADBEEF_CAFEF00D) begin
      failures++;
      $display("FAIL latency_read port1 got=%h expected=deadbeefcafef00d", rd_data[W +: W]);
    end
  endtask

  task automatic test_bypass();
    logic [W-1:0] r4;
    r4 = {$urandom, $urandom};
    wr_en = 1'b1; wr_addr = 5'd4; wr_data = r4;
    cycle();
    wr_addr = 5'd3; wr_data = 64'h1234;
    rd_addr = {5'd4, 5'd3};
    cycle();
    checks++;
    if (rd_data[0 +: W] !== 64'h1234) begin
      failures++;
      $display("FAIL bypass_port0 got=%h expected=1234", rd_data[0 +: W]);
    end
    checks++;
    if (rd_data[W +: W] !== r4) begin
      failures++;
      $display("FAIL bypass_port1 got=%h expected=%h", rd_data[W +: W], r4);
    end
    wr_en = 1'b0;
    cycle();
    for (int k = 0; k < NR; k++) begin
      checks++;
      if (rd_data[k*W +: W] !== m_exp[k]) begin
        failures++;
        $display("FAIL bypass_after port%0d got=%h expected=%h", k, rd_data[k*W +: W], m_exp[k]);
      end
    end
  endtask

  task automatic test_init();
    int busy_cnt;
    logic [W-1:0] want [4];
    idle_inputs();
    init_req = 1'b1;
    cycle();
    init_req = 1'b0;
    busy_cnt = (init_busy === 1'b1) ? 1 : 0;
    for (int c = 0; c < 40; c++) begin
      wr_en    = (c == 10);
      wr_addr  = 5'd5;
      wr_data  = 64'hFF;
      init_req = (c == 4);
      for (int k = 0; k < NR; k++) rd_addr[k*AW +: AW] = AW'($urandom_range(0, D - 1));
      cycle();
      if (init_busy === 1'b1) busy_cnt++;
      checks++;
      if (init_busy !== m_init) begin
        failures++;
        $display("FAIL init_busy c=%0d got=%b expected=%b", c, init_busy, m_init);
      end
      for (int k = 0; k < NR; k++) begin
        checks++;
        if (rd_data[k*W +: W] !== m_exp[k]) begin
          failures++;
          $display("FAIL init_read c=%0d port%0d got=%h expected=%h", c, k, rd_data[k*W +: W], m_exp[k]);
        end
      end
    end
    idle_inputs();
    checks++;
    if (busy_cnt != D) begin
      failures++;
      $display("FAIL init_duration got=%0d expected=%0d", busy_cnt, D);
    end
    want[0] = 64'd0; want[1] = 64'd17; want[2] = 64'd30; want[3] = 64'd5;
    rd_addr = {5'd17, 5'd0};
    cycle();
    for (int k = 0; k < NR; k++) begin
      checks++;
      if (rd_data[k*W +: W] !== want[k]) begin
        failures++;
        $display("FAIL init_value port%0d got=%h expected=%h", k, rd_data[k*W +: W], want[k]);
      end
    end
    rd_addr = {5'd5, 5'd30};
    cycle();
    for (int k = 0; k < NR; k++) begin
      checks++;
      if (rd_data[k*W +: W] !== want[k+2]) begin
        failures++;
        $display("FAIL init_value2 port%0d got=%h expected=%h", k, rd_data[k*W +: W], want[k+2]);
      end
    end
  endtask

  task automatic test_write_and_init();
    logic [W-1:0] v;
    v = {$urandom, $urandom};
    wr_en = 1'b1; wr_addr = 5'd20; wr_data = v; init_req = 1'b1;
    cycle();
    wr_en = 1'b0; init_req = 1'b0;
    rd_addr = {5'd0, 5'd20};
    cycle();
    checks++;
    if (rd_data[0 +: W] !== v) begin
      failures++;
      $display("FAIL write_then_init got=%h expected=%h", rd_data[0 +: W], v);
    end
    for (int c = 0; c < 40 && m_init; c++) cycle();
    checks++;
    if (init_busy !== 1'b0) begin
      failures++;
      $display("FAIL write_then_init_done busy=%b expected=0", init_busy);
    end
  endtask

  task automatic test_reset_mid_init();
    idle_inputs();
    init_req = 1'b1;
    cycle();
    init_req = 1'b0;
    for (int c = 0; c < 9; c++) cycle();
    reset = 1'b0;
    #1;
    model_reset();
    checks++;
    if (init_busy !== 1'b0 || rd_data !== '0) begin
      failures++;
      $display("FAIL reset_mid_init busy=%b rd_data=%h expected 0/0", init_busy, rd_data);
    end
    @(negedge clk) reset = 1'b1;
    for (int c = 0; c < 4; c++) begin
      for (int k = 0; k < NR; k++) rd_addr[k*AW +: AW] = AW'($urandom_range(0, D - 1));
      cycle();
      checks++;
      if (rd_data !== '0 || init_busy !== 1'b0) begin
        failures++;
        $display("FAIL reset_cleared c=%0d rd_data=%h busy=%b expected 0", c, rd_data, init_busy);
      end
    end
    init_req = 1'b1;
    cycle();
    init_req = 1'b0;
    for (int c = 0; c < 40 && m_init; c++) cycle();
    rd_addr = {5'd12, 5'd3};
    cycle();
    checks++;
    if (rd_data[0 +: W] !== 64'd3 || rd_data[W +: W] !== 64'd12) begin
      failures++;
      $display("FAIL reinit_value got=%h expected=%h", rd_data, {64'd12, 64'd3});
    end
  endtask

  task automatic test_zero_reg();
    logic [W-1:0] want;
    want = ZR ? 64'h0 : 64'hAA;
    wr_en = 1'b1; wr_addr = 5'd31; wr_data = 64'hAA;
    rd_addr = {5'd0, 5'd31};
    cycle();
    checks++;
    if (rd_data[0 +: W] !== want) begin
      failures++;
      $display("FAIL zero_reg_bypass got=%h expected=%h", rd_data[0 +: W], want);
    end
    wr_en = 1'b0;
    rd_addr = {5'd31, 5'd0};
    cycle();
    checks++;
    if (rd_data[W +: W] !== want) begin
      failures++;
      $display("FAIL zero_reg_read got=%h expected=%h", rd_data[W +: W], want);
    end
  endtask

  task automatic test_out_of_range();
    logic [W2-1:0] old4;
    idle_inputs();
    wr_en2 = 1'b1; wr_addr2 = 5'd4; wr_data2 = 16'hBEEF;
    cycle();
    old4 = m2_mem[4];
    wr_addr2 = 5'd28; wr_data2 = 16'h5A5A;
    rd_addr2 = {5'd29, 5'd4, 5'd28};
    cycle();
    checks++;
    if (rd_data2 !== {16'h0, old4, 16'h0}) begin
      failures++;
      $display("FAIL oor_bypass got=%h expected=%h", rd_data2, {16'h0, old4, 16'h0});
    end
    wr_en2 = 1'b0;
    for (int c = 0; c < 8; c++) begin
      for (int k = 0; k < NR2; k++) rd_addr2[k*AW2 +: AW2] = AW2'($urandom_range(0, D2 - 1));
      cycle();
      for (int k = 0; k < NR2; k++) begin
        checks++;
        if (rd_data2[k*W2 +: W2] !== m2_exp[k]) begin
          failures++;
          $display("FAIL oor_alias port%0d got=%h expected=%h", k, rd_data2[k*W2 +: W2], m2_exp[k]);
        end
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      randomize_inputs(1'b1);
      cycle();
      checks++;
      if (init_busy !== m_init || init_busy2 !== 1'b0) begin
        failures++;
        $display("FAIL rand_busy c=%0d got=%b/%b expected=%b/0", c, init_busy, init_busy2, m_init);
      end
      for (int k = 0; k < NR; k++) begin
        checks++;
        if (rd_data[k*W +: W] !== m_exp[k]) begin
          failures++;
          $display("FAIL rand_rd c=%0d port%0d got=%h expected=%h", c, k, rd_data[k*W +: W], m_exp[k]);
        end
      end
      for (int k = 0; k < NR2; k++) begin
        checks++;
        if (rd_data2[k*W2 +: W2] !== m2_exp[k]) begin
          failures++;
          $display("FAIL rand_rd2 c=%0d port%0d got=%h expected=%h", c, k, rd_data2[k*W2 +: W2], m2_exp[k]);
        end
      end
    end
    idle_inputs();
    for (int c = 0; c < 40 && m_init; c++) cycle();
  endtask

  initial begin
    test_reset();
    test_write_latency();
    test_bypass();
    test_init();
    test_write_and_init();
    test_reset_mid_init();
    test_zero_reg();
    test_out_of_range();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-read-port register file for the ARM datapath.
- Supersedes the fixed 32x64, 2-read register file.
- Adds configurable width, depth and read-port count, write-first bypass, a sequenced init mode (mem[i]=i, one entry per cycle), and an optional hard-wired zero register.
- Sits between decode (addresses) and ALU operand latches (registered read data).

Parameters:
- WIDTH, 64, data bits per register
- DEPTH, 32, number of registers (>=2; need not be a power of 2)
- NUM_RD, 2, number of read ports (1..4)
- AW, $clog2(DEPTH), address width (derived; do not override)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- init_req  in  1  one-cycle pulse; starts the init sequence
- init_busy  out  1  high while the init sequence runs
- rd_addr  in  NUM_RD*AW  packed read addresses; port k = bits [k*AW +: AW]
- rd_data  out  NUM_RD*WIDTH  packed registered read data; port k = bits [k*WIDTH +: WIDTH]
- wr_en  in  1  write strobe
- wr_addr  in  AW  write address
- wr_data  in  WIDTH  write data

Behaviour:
- Reset (reset=0, asynchronous):
  - all DEPTH entries = 0; rd_data = 0; init_busy = 0; FSM = IDLE; init counter = 0.
  - Reset asserted mid-init aborts the sequence; array is cleared.
- Read:
  - 1-cycle latency: rd_data[k] at edge N+1 = contents addressed by rd_addr[k] at edge N.
  - Every port updates every cycle; there is no read enable.
- Write:
  - On a rising edge with wr_en=1 and state IDLE, mem[wr_addr] <= wr_data.
- Bypass (write-first):
  - If wr_en=1, state is IDLE and rd_addr[k]==wr_addr in the same cycle, rd_data[k] <= wr_data, not the old contents.
  - Applies independently to every port.
- Out of range (addr >= DEPTH):
  - write is ignored;
  - read returns 0;
  - no bypass.
- Init FSM (states IDLE, INIT):
  - IDLE -> INIT on init_req=1. init_busy goes high the cycle after the request edge; counter = 0.
  - In INIT, each edge: mem[cnt] <= cnt, zero-extended (truncated if AW > WIDTH); cnt++.
  - INIT -> IDLE on the edge that writes cnt==DEPTH-1; init_busy drops the next cycle.
  - Total busy duration: DEPTH cycles.
  - init_req while in INIT is ignored (no restart).
  - External wr_en while in INIT is dropped silently; the caller must hold writes.
  - Reads during INIT return array contents. Bypass applies to the init write: rd_addr==cnt returns cnt.
  - wr_en and init_req asserted on the same IDLE edge: the write is performed, then INIT starts.

Optional Feature:
- Macro: REGFILE_ZERO_REG_EN
- Defined: entry DEPTH-1 (XZR, entry 31 at default depth) is hard-wired to 0.
  - Writes to it are ignored, including init writes.
  - Reads return 0, with no bypass.
  - Its storage may be optimised away.
- Undefined: entry DEPTH-1 is an ordinary register.

Decomposition:
- Package regfile_pkg:
  - state typedef (IDLE, INIT);
  - constants MAX_NUM_RD=4 and DEFAULT_WIDTH=64.
- Sub-module regfile_init_seq:
  - owns the FSM and counter;
  - outputs init_busy, init_we, init_addr, init_data (params DEPTH, AW, WIDTH).
- Top-level regfile_mp:
  - storage;
  - write mux (init path over external path);
  - per-port generate loop for read, bypass and range check.

Test Plan:
- Reset then read: release reset; read addrs 0, 5, 31 -> all rd_data = 0 one cycle later.
- Write/read latency: write 0xDEADBEEF_CAFEF00D to r7; next cycle read r7 on port 1 -> value appears on the following edge, not earlier.
- Bypass: same cycle wr_en=1, wr_addr=3, wr_data=0x1234, rd_addr[0]=3, rd_addr[1]=4 -> port0=0x1234, port1=old r4.
- Init: pulse init_req -> init_busy high for exactly 32 cycles. Afterwards read r0, r17, r30 -> 0, 17, 30. A wr_en to r5=0xFF during busy is dropped; r5 reads 5.
- Reset mid-init: assert reset at init cycle 10 -> init_busy=0 immediately, all reads return 0, and a new init_req works normally.
- Zero register (macro on, then off), write 0xAA to r31 and read it back:
  - macro defined -> reads 0, including a same-cycle bypass read;
  - macro undefined -> reads 0xAA.
